// File: rtl/darc_lite_seq.sv
// darc_lite_seq: AXI4-Lite write/read-back self-test sequencer.
// Writes seed-derived words, reads them back, reports pass/fail.
module darc_lite_seq #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0,
  parameter int unsigned C_NUM_REGS = 4,
  parameter int unsigned C_TIMEOUT = 255
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            start,
  input  logic [31:0]                     seed,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic [2:0]                      err_code,
  output logic [7:0]                      fail_idx,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
  localparam int unsigned SW = DW / 8;

  localparam logic [15:0] TMO_LAST = 16'(C_TIMEOUT - 1);
  localparam logic [7:0]  LAST_IDX = 8'(C_NUM_REGS - 1);

  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_BRSP = 3'd1;
  localparam logic [2:0] ERR_RRSP = 3'd2;
  localparam logic [2:0] ERR_DATA = 3'd3;
  localparam logic [2:0] ERR_TMO  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA,
    S_CHECK,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_nxt;
  logic [2:0] w_cause;

  logic [31:0]   r_seed;
  logic [7:0]    r_idx;
  logic [DW-1:0] r_rdata;
  logic [15:0]   r_wait;
  logic          r_aw_done;
  logic          r_w_done;

  logic          r_awvalid;
  logic          r_wvalid;
  logic          r_bready;
  logic          r_arvalid;
  logic          r_rready;
  logic [AW-1:0] r_awaddr;
  logic [DW-1:0] r_wdata;
  logic [SW-1:0] r_wstrb;
  logic [AW-1:0] r_araddr;
  logic          r_busy;
  logic          r_done;
  logic          r_pass;
  logic [2:0]    r_err;
  logic [7:0]    r_fail;

  logic [31:0]   w_seed_n;
  logic [7:0]    w_idx_n;
  logic [DW-1:0] w_rdata_n;
  logic [15:0]   w_wait_n;
  logic          w_aw_done_n;
  logic          w_w_done_n;
  logic          w_awvalid_n;
  logic          w_wvalid_n;
  logic          w_bready_n;
  logic          w_arvalid_n;
  logic          w_rready_n;
  logic [AW-1:0] w_awaddr_n;
  logic [DW-1:0] w_wdata_n;
  logic [AW-1:0] w_araddr_n;
  logic          w_busy_n;
  logic          w_done_n;
  logic          w_pass_n;
  logic [2:0]    w_err_n;
  logic [7:0]    w_fail_n;

  logic          w_aw_hs;
  logic          w_w_hs;
  logic          w_aw_ok;
  logic          w_w_ok;
  logic          w_tmo;
  logic          w_last;
  logic          w_stay;
  logic [DW-1:0] w_pat;

  function automatic logic [AW-1:0] f_addr(input logic [7:0] idx);
    return C_BASE_ADDR + {{(AW-10){1'b0}}, idx, 2'b00};
  endfunction

  assign w_aw_hs = r_awvalid & M_AXI_AWREADY;
  assign w_w_hs  = r_wvalid & M_AXI_WREADY;
  assign w_aw_ok = r_aw_done | w_aw_hs;
  assign w_w_ok  = r_w_done | w_w_hs;
  assign w_tmo   = (r_wait == TMO_LAST);
  assign w_last  = (r_idx == LAST_IDX);
  assign w_pat   = r_seed ^ {4{r_idx}};
  assign w_stay  = (w_nxt == r_state);

  // State register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  // Next-state decode plus the result code carried into DONE
  always_comb begin
    w_nxt   = r_state;
    w_cause = ERR_NONE;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_nxt = S_WR_ADDR;
      end
      S_WR_ADDR: begin
        if (w_aw_ok && w_w_ok) begin
          w_nxt = S_WR_RESP;
        end else if (w_tmo) begin
          w_nxt   = S_DONE;
          w_cause = ERR_TMO;
        end
      end
      S_WR_RESP: begin
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != 2'b00) begin
            w_nxt   = S_DONE;
            w_cause = ERR_BRSP;
          end else begin
            w_nxt = S_RD_ADDR;
          end
        end else if (w_tmo) begin
          w_nxt   = S_DONE;
          w_cause = ERR_TMO;
        end
      end
      S_RD_ADDR: begin
        if (M_AXI_ARREADY) begin
          w_nxt = S_RD_DATA;
        end else if (w_tmo) begin
          w_nxt   = S_DONE;
          w_cause = ERR_TMO;
        end
      end
      S_RD_DATA: begin
        if (M_AXI_RVALID) begin
          if (M_AXI_RRESP != 2'b00) begin
            w_nxt   = S_DONE;
            w_cause = ERR_RRSP;
          end else begin
            w_nxt = S_CHECK;
          end
        end else if (w_tmo) begin
          w_nxt   = S_DONE;
          w_cause = ERR_TMO;
        end
      end
      S_CHECK: begin
        if (r_rdata != w_pat) begin
          w_nxt   = S_DONE;
          w_cause = ERR_DATA;
        end else if (w_last) begin
          w_nxt = S_DONE;
        end else begin
          w_nxt = S_WR_ADDR;
        end
      end
      S_DONE: begin
        w_nxt = S_IDLE;
      end
      default: begin
        w_nxt = S_IDLE;
      end
    endcase
  end

  // Next values of every registered output and datapath register
  always_comb begin
    w_seed_n    = r_seed;
    w_idx_n     = r_idx;
    w_rdata_n   = r_rdata;
    w_awaddr_n  = r_awaddr;
    w_wdata_n   = r_wdata;
    w_araddr_n  = r_araddr;
    w_pass_n    = r_pass;
    w_err_n     = r_err;
    w_fail_n    = r_fail;
    w_awvalid_n = 1'b0;
    w_wvalid_n  = 1'b0;
    w_wait_n    = w_stay ? r_wait + 16'd1 : 16'd0;
    w_aw_done_n = 1'b0;
    w_w_done_n  = 1'b0;

    if (r_state == S_WR_ADDR && w_stay) begin
      w_aw_done_n = w_aw_ok;
      w_w_done_n  = w_w_ok;
    end

    if (r_state == S_IDLE && start) begin
      w_seed_n = seed;
      w_idx_n  = 8'd0;
      w_pass_n = 1'b0;
      w_err_n  = ERR_NONE;
      w_fail_n = 8'd0;
    end

    if (r_state == S_CHECK && w_nxt == S_WR_ADDR) begin
      w_idx_n = r_idx + 8'd1;
    end

    if (w_nxt == S_WR_ADDR) begin
      if (r_state != S_WR_ADDR) begin
        w_awvalid_n = 1'b1;
        w_wvalid_n  = 1'b1;
        w_awaddr_n  = f_addr(w_idx_n);
        w_wdata_n   = w_seed_n ^ {4{w_idx_n}};
      end else begin
        w_awvalid_n = r_awvalid & ~w_aw_hs;
        w_wvalid_n  = r_wvalid & ~w_w_hs;
      end
    end

    if (w_nxt == S_RD_ADDR && r_state != S_RD_ADDR) begin
      w_araddr_n = f_addr(r_idx);
    end

    if (r_state == S_RD_DATA && M_AXI_RVALID) begin
      w_rdata_n = M_AXI_RDATA;
    end

    if (w_nxt == S_DONE && r_state != S_DONE) begin
      w_pass_n = (w_cause == ERR_NONE);
      w_err_n  = w_cause;
      w_fail_n = (w_cause == ERR_NONE) ? 8'd0 : r_idx;
    end

    w_bready_n  = (w_nxt == S_WR_RESP);
    w_arvalid_n = (w_nxt == S_RD_ADDR);
    w_rready_n  = (w_nxt == S_RD_DATA);
    w_busy_n    = (w_nxt != S_IDLE);
    w_done_n    = (r_state == S_DONE);
  end

  // Output and datapath registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_seed    <= '0;
      r_idx     <= '0;
      r_rdata   <= '0;
      r_wait    <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_araddr  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_err     <= '0;
      r_fail    <= '0;
    end else begin
      r_seed    <= w_seed_n;
      r_idx     <= w_idx_n;
      r_rdata   <= w_rdata_n;
      r_wait    <= w_wait_n;
      r_aw_done <= w_aw_done_n;
      r_w_done  <= w_w_done_n;
      r_awvalid <= w_awvalid_n;
      r_wvalid  <= w_wvalid_n;
      r_bready  <= w_bready_n;
      r_arvalid <= w_arvalid_n;
      r_rready  <= w_rready_n;
      r_awaddr  <= w_awaddr_n;
      r_wdata   <= w_wdata_n;
      r_wstrb   <= '1;
      r_araddr  <= w_araddr_n;
      r_busy    <= w_busy_n;
      r_done    <= w_done_n;
      r_pass    <= w_pass_n;
      r_err     <= w_err_n;
      r_fail    <= w_fail_n;
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign err_code      = r_err;
  assign fail_idx      = r_fail;
  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

endmodule

// File: doc/darc_lite_seq.md
# darc_lite_seq

Hardware write/read-back sequencer that owns an AXI4-Lite master port into the DARC_BRAM2 S00_AXI register space. On a start pulse it writes C_NUM_REGS words derived from a seed to consecutive register addresses, reads each one back, compares, and reports pass/fail with an error code and failing index. It replaces BFM-driven register tests with a synthesizable self-test that sits between the control logic and the DARC_BRAM2 slave.

## Interface
Parameters:
- C_M_AXI_ADDR_WIDTH, 32, AXI address width
- C_M_AXI_DATA_WIDTH, 32, AXI data width (only 32 supported)
- C_BASE_ADDR, 32'h0000_0000, address of register 0; register i at C_BASE_ADDR + 4*i
- C_NUM_REGS, 4, registers exercised (1..256)
- C_TIMEOUT, 255, maximum wait cycles per handshake (1..65535)

Ports:
- ACLK  in  1  clock; all logic on rising edge
- ARESETN  in  1  reset, asynchronous assert, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- seed  in  32  pattern seed, latched on accepted start
- busy  out  1  high from the cycle after start is accepted until DONE
- done  out  1  one-cycle pulse at end of run (pass or fail)
- pass  out  1  result of last run; held until next accepted start
- err_code  out  3  0 none, 1 BRESP≠OKAY, 2 RRESP≠OKAY, 3 data mismatch, 4 timeout
- fail_idx  out  8  register index where the run stopped on error, else 0
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY  out/out/out/in  32/3/1/1  write address channel
- M_AXI_WDATA/WSTRB/WVALID/WREADY  out/out/out/in  32/4/1/1  write data channel
- M_AXI_BRESP/BVALID/BREADY  in/in/out  2/1/1  write response channel
- M_AXI_ARADDR/ARPROT/ARVALID/ARREADY  out/out/out/in  32/3/1/1  read address channel
- M_AXI_RDATA/RRESP/RVALID/RREADY  in/in/in/out  32/2/1/1  read data channel

## Operation
- States: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, CHECK, DONE.
- IDLE: start=1 → latch seed, idx=0, clear pass/err_code/fail_idx, go WR_ADDR. start while busy ignored.
- Pattern: data_i = seed XOR {4{idx[7:0]}}; address = C_BASE_ADDR + (idx<<2), modulo 2^32.
- WR_ADDR: AWVALID and WVALID asserted together; each drops independently after its own handshake; leave for WR_RESP once both handshaken (same cycle allowed).
- WR_RESP: BREADY=1; on BVALID: BRESP≠00 → DONE with err 1, else RD_ADDR.
- RD_ADDR: ARVALID=1 until ARREADY → RD_DATA.
- RD_DATA: RREADY=1; on RVALID capture RDATA; RRESP≠00 → DONE with err 2, else CHECK.
- CHECK: captured≠data_i → DONE with err 3; else idx==C_NUM_REGS-1 → DONE with pass=1; else idx+1 → WR_ADDR.
- Timeout: per-state wait counter, cleared on state change; reaching C_TIMEOUT in any wait state → DONE with err 4; all VALID/READY drop (abort, for hung slave only).
- On error fail_idx=idx. AWPROT=ARPROT=0, WSTRB=4'hF constant.
- DONE: done=1 one cycle, busy=0, → IDLE.

## Timing
- Reset: every output 0 (all VALID/READY, busy, done, pass, err_code, fail_idx, addr/data buses); state IDLE. Reset mid-run aborts immediately; no resume.
- All outputs registered. AxADDR/WDATA stable while respective VALID high.
- BREADY only in WR_RESP; RREADY only in RD_DATA.
- Zero-wait slave (READYs high, BVALID/RVALID one cycle after handshake): 5 cycles per register; done pulses 5*C_NUM_REGS+1 cycles after the start-sampling edge.
- busy high in cycle after start accept; done and busy=0 in same cycle; pass/err valid when done=1.
- AWREADY before WREADY, or reverse, by any gap: no duplicate handshake on either channel.

## Test plan
- Zero-wait slave with RAM model, seed 32'h0101FFFF, C_NUM_REGS=4 → writes 0101FFFF, 0000FEFE... (XOR pattern) to 0x0,0x4,0x8,0xC; done at cycle 21; pass=1, err_code=0.
- Slave delays AWREADY 3 cycles, WREADY 0 cycles, RVALID 4 cycles → one AW and one W handshake per register, pass=1.
- Slave returns BRESP=2'b10 on register 2 → done, pass=0, err_code=1, fail_idx=2, no AR issued for register 2.
- Slave corrupts RDATA bit 0 on register 3 → err_code=3, fail_idx=3.
- Slave never asserts ARREADY, C_TIMEOUT=16 → err_code=4 after 16 wait cycles in RD_ADDR, ARVALID=0 afterwards.
- ARESETN low during RD_DATA of register 1 → all outputs 0 asynchronously; next start runs a full clean pass from register 0.
